// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, field width and FSM encoding shared by MMIO peripherals
package mmio_pkg;

  localparam logic [3:0] OFF_PORT_OUT  = 4'h0;
  localparam logic [3:0] OFF_PORT_IN   = 4'h4;
  localparam logic [3:0] OFF_STATUS    = 4'h8;
  localparam logic [3:0] OFF_CHG_COUNT = 4'hC;

  localparam int FIELD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/port_in_sync.sv
// port_in_sync: multi-flop synchronizer for asynchronous pins plus change detector
module port_in_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] syncOut,
  output logic             changed
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]                  prevOut;

  // Shift pins through the chain and keep a one-cycle-old copy of the synchronized value
  always_ff @(posedge clk) begin
    if (!reset) begin
      chain   <= '0;
      prevOut <= '0;
    end else begin
      chain   <= {chain[SYNC_STAGES-2:0], asyncIn};
      prevOut <= chain[SYNC_STAGES-1];
    end
  end

  assign syncOut = chain[SYNC_STAGES-1];
  assign changed = syncOut != prevOut;

endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: single-cycle-latency MMIO slave exposing an output port, a synchronized input port and change tracking
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut
);

  state_t               state, nextState;
  logic [31:0]          offset, loadData, respData, portOutReg;
  logic [3:0]           regSel;
  logic [7:0]           portInSync;
  logic [FIELD_W-1:0]   cnt;
  logic                 chg, changed, accept, badAddr, respErr;
  logic                 outWrite, cntWrite, clrChg;

  port_in_sync #(
    .WIDTH      (8),
    .SYNC_STAGES(SYNC_STAGES)
  ) portInSyncInst (
    .clk    (clk),
    .reset  (reset),
    .asyncIn(PortIn),
    .syncOut(portInSync),
    .changed(changed)
  );

  assign offset   = req_addr - BASE_ADDR;
  assign regSel   = offset[3:0];
  assign badAddr  = (req_addr[1:0] != 2'b00) || (offset > 32'hC);
  assign req_ready = (state == IDLE) && reset;
  assign accept   = req_ready && req_valid;
  assign outWrite = accept && req_write && !badAddr && regSel == OFF_PORT_OUT;
  assign cntWrite = accept && req_write && !badAddr && regSel == OFF_CHG_COUNT;
  assign clrChg   = accept && !req_write && !badAddr && regSel == OFF_STATUS;

  // Register-map read mux evaluated on the accepted request
  always_comb begin
    loadData = regSel == OFF_PORT_OUT ? portOutReg :
               regSel == OFF_PORT_IN  ? {24'b0, portInSync} :
               regSel == OFF_STATUS   ? {31'b0, chg} :
                                        {{(32-FIELD_W){1'b0}}, cnt};
  end

  // Next-state logic: every accepted request spends exactly one cycle in RESP
  always_comb begin
    nextState = IDLE;
    nextState = (state == IDLE && accept) ? RESP : IDLE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Capture the response at acceptance so RESP reports pre-update register contents
  always_ff @(posedge clk) begin
    if (!reset) begin
      respErr  <= 1'b0;
      respData <= '0;
    end else if (accept) begin
      respErr  <= badAddr;
      respData <= (badAddr || req_write) ? '0 : loadData;
    end
  end

  // Output port register; a store lands at acceptance so PortOut shows it in RESP
  always_ff @(posedge clk) begin
    if (!reset)        portOutReg <= '0;
    else if (outWrite) portOutReg <= req_wdata;
  end

  // Sticky change flag: a change event beats a concurrent read-to-clear
  always_ff @(posedge clk) begin
    if (!reset) chg <= 1'b0;
    else        chg <= changed ? 1'b1 : (clrChg ? 1'b0 : chg);
  end

  // Saturating change counter; a clearing write that meets a change event leaves 1
  always_ff @(posedge clk) begin
    if (!reset)                    cnt <= '0;
    else if (cntWrite)             cnt <= {{(FIELD_W-1){1'b0}}, changed};
    else if (changed && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign resp_valid = (state == RESP) && reset;
  assign resp_err   = resp_valid && respErr;
  assign resp_rdata = resp_valid ? respData : '0;
  assign PortOut    = portOutReg;

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: directed vector table plus hand sequences for mmio_port_responder
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, PortOut;
  logic [7:0]  PortIn;

  int checks   = 0;
  int failures = 0;
  logic [31:0] lastPortOut;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    logic [31:0] expPortOut;
    string       name;
  } vec_t;

  vec_t vecs[15];

  mmio_port_responder #(
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .PortIn    (PortIn),
    .PortOut   (PortOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at an IDLE negedge; returns at the following IDLE negedge
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic expErr, input logic [31:0] expRd, input string nm);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
    chk({nm, "_novalid_at_accept"}, {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    chk({nm, "_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({nm, "_err"}, {31'b0, resp_err}, {31'b0, expErr});
    chk({nm, "_rdata"}, resp_rdata, expRd);
    lastPortOut = PortOut;
    @(negedge clk);
    chk({nm, "_valid_drop"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, BASE + 32'h0,  32'hA5A50001, 1'b0, 32'h0,        32'hA5A50001, "st_out"};
    vecs[1]  = '{1'b0, BASE + 32'h0,  32'h0,        1'b0, 32'hA5A50001, 32'hA5A50001, "ld_out"};
    vecs[2]  = '{1'b0, BASE + 32'h4,  32'h0,        1'b0, 32'h0,        32'hA5A50001, "ld_in"};
    vecs[3]  = '{1'b0, BASE + 32'h8,  32'h0,        1'b0, 32'h0,        32'hA5A50001, "ld_status"};
    vecs[4]  = '{1'b0, BASE + 32'hC,  32'h0,        1'b0, 32'h0,        32'hA5A50001, "ld_cnt"};
    vecs[5]  = '{1'b1, BASE + 32'h4,  32'hFFFFFFFF, 1'b0, 32'h0,        32'hA5A50001, "st_in_ignored"};
    vecs[6]  = '{1'b1, BASE + 32'h8,  32'hFFFFFFFF, 1'b0, 32'h0,        32'hA5A50001, "st_status_ignored"};
    vecs[7]  = '{1'b0, BASE + 32'h4,  32'h0,        1'b0, 32'h0,        32'hA5A50001, "ld_in_again"};
    vecs[8]  = '{1'b0, BASE + 32'h2,  32'h0,        1'b1, 32'h0,        32'hA5A50001, "ld_misaligned"};
    vecs[9]  = '{1'b0, BASE + 32'h10, 32'h0,        1'b1, 32'h0,        32'hA5A50001, "ld_past_end"};
    vecs[10] = '{1'b1, BASE + 32'h1,  32'hDEADBEEF, 1'b1, 32'h0,        32'hA5A50001, "st_misaligned"};
    vecs[11] = '{1'b1, BASE - 32'h4,  32'h00000000, 1'b1, 32'h0,        32'hA5A50001, "st_below_base"};
    vecs[12] = '{1'b0, 32'h00000000,  32'h0,        1'b1, 32'h0,        32'hA5A50001, "ld_far"};
    vecs[13] = '{1'b1, BASE + 32'hC,  32'h00001234, 1'b0, 32'h0,        32'hA5A50001, "st_cnt"};
    vecs[14] = '{1'b0, BASE + 32'h0,  32'h0,        1'b0, 32'hA5A50001, 32'hA5A50001, "ld_out_kept"};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PortIn    = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_portout", PortOut, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_rst_err", {31'b0, resp_err}, 32'd0);
    chk("post_rst_rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].expErr, vecs[i].expRdata, vecs[i].name);
      chk({vecs[i].name, "_portout"}, lastPortOut, vecs[i].expPortOut);
    end

    PortIn = 8'h3C;
    repeat (4) @(negedge clk);
    access(1'b0, BASE + 32'h4, 32'h0, 1'b0, 32'h3C, "chg_ld_in");
    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h1,  "chg_status_set");
    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h0,  "chg_status_cleared");
    access(1'b0, BASE + 32'hC, 32'h0, 1'b0, 32'h1,  "chg_cnt_one");
    access(1'b1, BASE + 32'hC, 32'h0, 1'b0, 32'h0,  "cnt_clear");
    access(1'b0, BASE + 32'hC, 32'h0, 1'b0, 32'h0,  "cnt_zero");

    for (int i = 0; i < 65537; i++) begin
      PortIn = ~PortIn;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    access(1'b0, BASE + 32'hC, 32'h0, 1'b0, 32'h0000FFFF, "cnt_saturated");

    PortIn = ~PortIn;
    repeat (2) @(negedge clk);
    access(1'b1, BASE + 32'hC, 32'hCAFEF00D, 1'b0, 32'h0, "cnt_write_with_toggle");
    access(1'b0, BASE + 32'hC, 32'h0, 1'b0, 32'h1, "cnt_after_write_toggle");

    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h1, "status_clear_pre");
    PortIn = ~PortIn;
    repeat (2) @(negedge clk);
    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h0, "status_clear_vs_set");
    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h1, "status_set_won");
    access(1'b0, BASE + 32'h8, 32'h0, 1'b0, 32'h0, "status_cleared_after");

    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = BASE;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_ready_%0d", i), {31'b0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_valid_%0d", i), {31'b0, resp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = BASE;
    req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    chk("rr_store_landed", PortOut, 32'h12345678);
    reset = 1'b0;
    #1;
    chk("rr_valid_suppressed", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("rr_portout_cleared", PortOut, 32'd0);
    chk("rr_ready_in_reset", {31'b0, req_ready}, 32'd0);
    chk("rr_valid_in_reset", {31'b0, resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_ready_after", {31'b0, req_ready}, 32'd1);
    chk("rr_valid_after", {31'b0, resp_valid}, 32'd0);
    access(1'b0, BASE, 32'h0, 1'b0, 32'h0, "rr_ld_out");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
